// File: rtl/led_rgb_pkg.sv
// led_rgb_pkg: shared definitions for the RGB LED driver.
//   mode_t       : operating modes selected by {sw1, sw0}
//   R/G/B_IDX    : bit positions of each colour within one LED's 3-bit slice
//   decode_colour: maps the 4-bit colour select onto {B,G,R}; the white bit
//                  forces all three channels on.
package led_rgb_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_STATIC = 2'b01,
        MODE_BLINK  = 2'b10,
        MODE_CHASE  = 2'b11
    } mode_t;

    localparam int R_IDX = 0;
    localparam int G_IDX = 1;
    localparam int B_IDX = 2;

    function automatic logic [2:0] decode_colour(input logic [3:0] sel);
        return sel[2:0] | {3{sel[3]}};
    endfunction

endpackage

// File: rtl/led_pwm_timebase.sv
// led_pwm_timebase: brightness PWM and blink/chase step generator.
// Optional feature: define GAMMA_EN to apply a square-law curve to the
// brightness value before it is latched as the PWM duty.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clr         : clears the period counter (mode change)
//   brightness  : requested duty, sampled only at the PWM period boundary
//   pwm_on      : high while the PWM counter is below the latched duty
//   step        : one-clk pulse every BLINK_PERIODS PWM periods
module led_pwm_timebase #(
    parameter int PWM_W         = 8,
    parameter int PRESCALE      = 125,
    parameter int BLINK_PERIODS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PWM_W-1:0] brightness,
    output logic             pwm_on,
    output logic             step
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PER_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

    logic [PRE_W-1:0] pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] duty_next;
    logic [PER_W-1:0] per_cnt;
    logic             tick;
    logic             boundary;
    logic             per_last;

    // With PRESCALE=1 pre_cnt never leaves 0, so tick is constantly high.
    assign tick     = (pre_cnt == PRE_W'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt == {PWM_W{1'b1}});
    assign per_last = (per_cnt == PER_W'(BLINK_PERIODS - 1));

`ifdef GAMMA_EN
    // Full-width square, keep the upper half (truncating divide by 2^PWM_W).
    logic [2*PWM_W-1:0] sq;
    assign sq        = {{PWM_W{1'b0}}, brightness} * {{PWM_W{1'b0}}, brightness};
    assign duty_next = sq[2*PWM_W-1:PWM_W];
`else
    assign duty_next = brightness;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            duty    <= '0;
            per_cnt <= '0;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;   // natural wrap at 2^PWM_W
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            // Duty only moves at the period boundary so a period is never split.
            if (boundary) begin
                duty <= duty_next;
            end

            // A mode change restarts the blink/chase timing immediately.
            if (clr) begin
                per_cnt <= '0;
            end else if (boundary) begin
                per_cnt <= per_last ? '0 : per_cnt + 1'b1;
            end
        end
    end

    assign pwm_on = (pwm_cnt < duty);
    assign step   = boundary && per_last;

endmodule

// File: rtl/led_rgb_pwm.sv
// led_rgb_pwm: RGB LED driver with static, blink and chase modes plus PWM
// brightness. Optional feature: GAMMA_EN (square-law brightness curve,
// implemented inside led_pwm_timebase).
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   sw0, sw1    : mode select (asynchronous switches, synchronised here)
//   in          : colour select, in[0]=R in[1]=G in[2]=B in[3]=white
//   brightness  : PWM duty, quasi-static, not synchronised
//   out         : registered LED drive, LED k uses out[3k+2:3k] = {B,G,R}
module led_rgb_pwm
    import led_rgb_pkg::*;
#(
    parameter int N_LED         = 2,
    parameter int PWM_W         = 8,
    parameter int PRESCALE      = 125,
    parameter int BLINK_PERIODS = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sw0,
    input  logic               sw1,
    input  logic [3:0]         in,
    input  logic [PWM_W-1:0]   brightness,
    output logic [3*N_LED-1:0] out
);

    localparam int IDX_W = (N_LED > 1) ? $clog2(N_LED) : 1;

    logic [1:0]       sw_p0, sw_p1;
    logic [3:0]       in_p0, in_p1;
    mode_t            mode, mode_q;
    logic             mode_chg;
    logic [2:0]       col;
    logic             pwm_on;
    logic             step;
    logic             phase, phase_d, phase_eff;
    logic [IDX_W-1:0] idx, idx_d, idx_eff;
    logic [3*N_LED-1:0] out_d;

    // Stage p0/p1: two-flop synchronisers for the switches and colour select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_p0 <= '0;
            sw_p1 <= '0;
            in_p0 <= '0;
            in_p1 <= '0;
        end else begin
            sw_p0 <= {sw1, sw0};
            sw_p1 <= sw_p0;
            in_p0 <= in;
            in_p1 <= in_p0;
        end
    end

    assign mode     = mode_t'(sw_p1);
    assign mode_chg = (mode != mode_q);
    assign col      = decode_colour(in_p1);

    led_pwm_timebase #(
        .PWM_W        (PWM_W),
        .PRESCALE     (PRESCALE),
        .BLINK_PERIODS(BLINK_PERIODS)
    ) u_timebase (
        .clk       (clk),
        .rst       (rst),
        .clr       (mode_chg),
        .brightness(brightness),
        .pwm_on    (pwm_on),
        .step      (step)
    );

    // Mode/phase/index state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            phase  <= 1'b1;
            idx    <= '0;
        end else begin
            mode_q <= mode;
            phase  <= phase_d;
            idx    <= idx_d;
        end
    end

    always_comb begin
        phase_d   = phase;
        idx_d     = idx;
        phase_eff = phase;
        idx_eff   = idx;
        out_d     = '0;

        // Phase and index run in every mode; only blink/chase look at them,
        // and any mode change restarts them, so entering a mode is always clean.
        if (mode_chg) begin
            phase_d   = 1'b1;
            idx_d     = '0;
            phase_eff = 1'b1;
            idx_eff   = '0;
        end else if (step) begin
            phase_d = ~phase;
            idx_d   = (idx == IDX_W'(N_LED - 1)) ? '0 : idx + 1'b1;
        end

        for (int k = 0; k < N_LED; k++) begin
            logic lit;
            case (mode)
                MODE_STATIC: lit = pwm_on;
                MODE_BLINK:  lit = pwm_on & phase_eff;
                MODE_CHASE:  lit = pwm_on & (idx_eff == IDX_W'(k));
                default:     lit = 1'b0;
            endcase
            out_d[3*k+R_IDX] = col[R_IDX] & lit;
            out_d[3*k+G_IDX] = col[G_IDX] & lit;
            out_d[3*k+B_IDX] = col[B_IDX] & lit;
        end
    end

    // Output register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= out_d;
        end
    end

endmodule
